inert_snsr_serf: RTL and testbench

INERT_SNSR_SERF -- requirements
Module: inert_snsr_serf

---
 rtl/inert_snsr_serf.sv | 251 +++++++++++++++++++++++++
 tb/tb_inert_snsr_serf.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/inert_snsr_serf.sv
// Inertial sensor SPI serf: 16-bit frames, config regs, sample holding regs, INT.
// Ports: clk, rst_n, SS_n/SCLK/MOSI/MISO (SPI), INT, new_smpl + five 16b samples,
// cfg_int/cfg_10/cfg_11/cfg_14 outputs. Optional macro: SNSR_STATUS_EN (0x1E status).
module inert_snsr_serf #(
  parameter logic [7:0] WHO_AM_I = 8'h6A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  output logic        INT,
  input  logic        new_smpl,
  input  logic [15:0] ptch_rt_in,
  input  logic [15:0] roll_rt_in,
  input  logic [15:0] yaw_rt_in,
  input  logic [15:0] ax_in,
  input  logic [15:0] ay_in,
  output logic [7:0]  cfg_int,
  output logic [7:0]  cfg_10,
  output logic [7:0]  cfg_11,
  output logic [7:0]  cfg_14
);

  logic ss_m_q, ss_s_q, ss_p_q;
  logic sck_m_q, sck_s_q, sck_p_q;
  logic mosi_m_q, mosi_s_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_m_q   <= 1'b1;
      ss_s_q   <= 1'b1;
      ss_p_q   <= 1'b1;
      sck_m_q  <= 1'b1;
      sck_s_q  <= 1'b1;
      sck_p_q  <= 1'b1;
      mosi_m_q <= 1'b0;
      mosi_s_q <= 1'b0;
    end else begin
      ss_m_q   <= SS_n;
      ss_s_q   <= ss_m_q;
      ss_p_q   <= ss_s_q;
      sck_m_q  <= SCLK;
      sck_s_q  <= sck_m_q;
      sck_p_q  <= sck_s_q;
      mosi_m_q <= MOSI;
      mosi_s_q <= mosi_m_q;
    end
  end

  logic ss_lo, ss_fall, busy;
  logic sck_rise, sck_fall;

  assign ss_lo    = ~ss_s_q;
  assign ss_fall  = ss_p_q & ~ss_s_q;
  // Either sync stage low counts as in-frame so holding regs freeze early.
  assign busy     = ~ss_s_q | ~ss_m_q;
  assign sck_rise = ss_lo & ~sck_p_q & sck_s_q;
  assign sck_fall = ss_lo & sck_p_q & ~sck_s_q;

  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] rx_q, rx_d;
  logic [7:0]  tx_q, tx_d;
  logic        miso_q, miso_d;
  logic [7:0]  cfg_int_q, cfg_int_d;
  logic [7:0]  cfg_10_q, cfg_10_d;
  logic [7:0]  cfg_11_q, cfg_11_d;
  logic [7:0]  cfg_14_q, cfg_14_d;
  logic [79:0] hold_q, hold_d;
  logic [79:0] shad_q, shad_d;
  logic        pend_q, pend_d;
  logic        upd_q, upd_d;
  logic        int_q, int_d;

  logic [7:0]  cmd8;
  logic [7:0]  wr_cmd;
  logic [6:0]  rd_addr;
  logic        cmd_rd;
  logic        wr_go;
  logic [79:0] smpl;

  assign cmd8    = {rx_q[6:0], mosi_s_q};
  assign wr_cmd  = rx_q[14:7];
  assign rd_addr = cmd8[6:0];
  assign cmd_rd  = sck_rise & (cnt_q == 4'd7) & cmd8[7];
  assign wr_go   = sck_rise & (cnt_q == 4'd15) & ~wr_cmd[7];
  assign smpl    = {ay_in, ax_in, yaw_rt_in, roll_rt_in, ptch_rt_in};

`ifdef SNSR_STATUS_EN
  logic ovr_q, ovr_d;
`endif

  logic       rd_hold;
  logic [3:0] rd_idx;
  logic [6:0] rd_off;
  logic [7:0] rdata;

  // 0x22..0x2B map to byte 0..9 of the packed holding vector.
  assign rd_hold = (rd_addr[6:4] == 3'h2) &&
                   (rd_addr[3:0] >= 4'h2) &&
                   (rd_addr[3:0] <= 4'hB);
  assign rd_idx  = rd_addr[3:0] - 4'd2;
  assign rd_off  = {rd_idx, 3'b000};

  always_comb begin
    rdata = 8'h00;
    unique case (1'b1)
      rd_hold:            rdata = hold_q[rd_off +: 8];
      rd_addr == 7'h0F:   rdata = WHO_AM_I;
      rd_addr == 7'h0D:   rdata = cfg_int_q;
      rd_addr == 7'h10:   rdata = cfg_10_q;
      rd_addr == 7'h11:   rdata = cfg_11_q;
      rd_addr == 7'h14:   rdata = cfg_14_q;
`ifdef SNSR_STATUS_EN
      rd_addr == 7'h1E:   rdata = {6'b0, ovr_q, int_q};
`endif
      default:            rdata = 8'h00;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    rx_d   = rx_q;
    tx_d   = tx_q;
    miso_d = miso_q;
    if (!ss_lo) begin
      cnt_d  = 4'd0;
      tx_d   = 8'h00;
      miso_d = 1'b0;
    end else if (ss_fall) begin
      cnt_d  = 4'd0;
      rx_d   = 15'd0;
      tx_d   = 8'h00;
      miso_d = 1'b0;
    end else begin
      if (sck_rise) begin
        rx_d  = {rx_q[13:0], mosi_s_q};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd7)
          tx_d = cmd8[7] ? rdata : 8'h00;
      end
      if (sck_fall) begin
        miso_d = tx_q[7];
        tx_d   = {tx_q[6:0], 1'b0};
      end
    end
  end

  always_comb begin
    cfg_int_d = cfg_int_q;
    cfg_10_d  = cfg_10_q;
    cfg_11_d  = cfg_11_q;
    cfg_14_d  = cfg_14_q;
    if (wr_go) begin
      unique case (1'b1)
        wr_cmd[6:0] == 7'h0D: cfg_int_d = cmd8;
        wr_cmd[6:0] == 7'h10: cfg_10_d  = cmd8;
        wr_cmd[6:0] == 7'h11: cfg_11_d  = cmd8;
        wr_cmd[6:0] == 7'h14: cfg_14_d  = cmd8;
        default:              cfg_int_d = cfg_int_q;
      endcase
    end
  end

  // Samples during a frame park in the shadow set (latest wins) and
  // move over once the frame has closed.
  always_comb begin
    hold_d = hold_q;
    shad_d = shad_q;
    pend_d = pend_q;
    upd_d  = 1'b0;
    if (busy) begin
      if (new_smpl) begin
        shad_d = smpl;
        pend_d = 1'b1;
      end
    end else if (new_smpl) begin
      hold_d = smpl;
      pend_d = 1'b0;
      upd_d  = 1'b1;
    end else if (pend_q) begin
      hold_d = shad_q;
      pend_d = 1'b0;
      upd_d  = 1'b1;
    end
  end

  always_comb begin
    int_d = int_q;
    if (cmd_rd && (rd_addr == 7'h22))
      int_d = 1'b0;
    if (upd_q && cfg_int_q[1])
      int_d = 1'b1;
  end

`ifdef SNSR_STATUS_EN
  always_comb begin
    ovr_d = ovr_q;
    if (cmd_rd && (rd_addr == 7'h1E))
      ovr_d = 1'b0;
    if (new_smpl && int_q)
      ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ovr_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= 4'd0;
      rx_q      <= 15'd0;
      tx_q      <= 8'h00;
      miso_q    <= 1'b0;
      cfg_int_q <= 8'h00;
      cfg_10_q  <= 8'h00;
      cfg_11_q  <= 8'h00;
      cfg_14_q  <= 8'h00;
      hold_q    <= 80'd0;
      shad_q    <= 80'd0;
      pend_q    <= 1'b0;
      upd_q     <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      miso_q    <= miso_d;
      cfg_int_q <= cfg_int_d;
      cfg_10_q  <= cfg_10_d;
      cfg_11_q  <= cfg_11_d;
      cfg_14_q  <= cfg_14_d;
      hold_q    <= hold_d;
      shad_q    <= shad_d;
      pend_q    <= pend_d;
      upd_q     <= upd_d;
      int_q     <= int_d;
    end
  end

  assign MISO    = miso_q;
  assign INT     = int_q;
  assign cfg_int = cfg_int_q;
  assign cfg_10  = cfg_10_q;
  assign cfg_11  = cfg_11_q;
  assign cfg_14  = cfg_14_q;

endmodule

// File: tb/tb_inert_snsr_serf.sv
// Directed bench for inert_snsr_serf: SPI frames, config, samples, INT.
module tb_inert_snsr_serf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        INT;
  logic        new_smpl = 1'b0;
  logic [15:0] ptch_rt_in = 16'h0;
  logic [15:0] roll_rt_in = 16'h0;
  logic [15:0] yaw_rt_in = 16'h0;
  logic [15:0] ax_in = 16'h0;
  logic [15:0] ay_in = 16'h0;
  logic [7:0]  cfg_int, cfg_10, cfg_11, cfg_14;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  inert_snsr_serf dut (
    .clk(clk), .rst_n(rst_n),
    .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
    .INT(INT), .new_smpl(new_smpl),
    .ptch_rt_in(ptch_rt_in), .roll_rt_in(roll_rt_in),
    .yaw_rt_in(yaw_rt_in), .ax_in(ax_in), .ay_in(ay_in),
    .cfg_int(cfg_int), .cfg_10(cfg_10),
    .cfg_11(cfg_11), .cfg_14(cfg_14)
  );

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_smpl(input logic [15:0] p);
    @(negedge clk);
    ptch_rt_in = p;
    new_smpl = 1'b1;
    @(negedge clk);
    new_smpl = 1'b0;
  endtask

  // MISO is sampled just before each SCLK rise, as the monarch would.
  task automatic spi_xfer(input logic [15:0] w, input int nbits,
                          input int smpl_at, input int rst_at,
                          input logic [15:0] sp,
                          output logic [15:0] r);
    r = 16'h0;
    SS_n = 1'b0;
    #100;
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = w[15-i];
      if (i == smpl_at) pulse_smpl(sp);
      if (i == rst_at) begin
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
      end
      #80;
      r[15-i] = MISO;
      SCLK = 1'b1;
      #80;
    end
    #80;
    SS_n = 1'b1;
    #200;
  endtask

  task automatic rd(input logic [15:0] w, output logic [15:0] r);
    spi_xfer(w, 16, -1, -1, 16'h0, r);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (MISO !== 1'b0) begin errs++;
      $display("FAIL reset_miso got %b want 0", MISO); end
    checks++; if (INT !== 1'b0) begin errs++;
      $display("FAIL reset_int got %b want 0", INT); end
    checks++; if (cfg_int !== 8'h00) begin errs++;
      $display("FAIL reset_cfg_int got %h want 00", cfg_int); end
    checks++; if ({cfg_10, cfg_11, cfg_14} !== 24'h0) begin errs++;
      $display("FAIL reset_cfg got %h want 000000",
               {cfg_10, cfg_11, cfg_14}); end
  endtask

  task automatic test_whoami;
    logic [15:0] r;
    rd(16'h8F00, r);
    checks++; if (r[7:0] !== 8'h6A) begin errs++;
      $display("FAIL whoami got %h want 6a", r[7:0]); end
    checks++; if (r[15:8] !== 8'h00) begin errs++;
      $display("FAIL cmd_miso got %h want 00", r[15:8]); end
    checks++; if (MISO !== 1'b0) begin errs++;
      $display("FAIL idle_miso got %b want 0", MISO); end
  endtask

  task automatic test_write_read;
    logic [15:0] r;
    rd(16'h0D02, r);
    checks++; if (cfg_int !== 8'h02) begin errs++;
      $display("FAIL wr_cfg_int got %h want 02", cfg_int); end
    rd(16'h8D00, r);
    checks++; if (r[7:0] !== 8'h02) begin errs++;
      $display("FAIL rd_cfg_int got %h want 02", r[7:0]); end
    rd(16'h10A5, r);
    rd(16'h145A, r);
    rd(16'h12FF, r);
    checks++; if ({cfg_10, cfg_11, cfg_14} !== 24'hA5005A) begin errs++;
      $display("FAIL wr_cfg got %h want a5005a",
               {cfg_10, cfg_11, cfg_14}); end
    rd(16'h9000, r);
    checks++; if (r[7:0] !== 8'hA5) begin errs++;
      $display("FAIL rd_cfg10 got %h want a5", r[7:0]); end
    rd(16'h9200, r);
    checks++; if (r[7:0] !== 8'h00) begin errs++;
      $display("FAIL rd_unmapped got %h want 00", r[7:0]); end
  endtask

  task automatic test_int;
    logic [15:0] r;
    roll_rt_in = 16'hBEEF;
    ay_in = 16'hC0DE;
    checks++; if (INT !== 1'b0) begin errs++;
      $display("FAIL int_pre got %b want 0", INT); end
    pulse_smpl(16'h1234);
    repeat (3) @(negedge clk);
    checks++; if (INT !== 1'b1) begin errs++;
      $display("FAIL int_set got %b want 1", INT); end
    rd(16'hA200, r);
    checks++; if (r[7:0] !== 8'h34) begin errs++;
      $display("FAIL rd_ptchL got %h want 34", r[7:0]); end
    checks++; if (INT !== 1'b0) begin errs++;
      $display("FAIL int_clr got %b want 0", INT); end
    rd(16'hA300, r);
    checks++; if (r[7:0] !== 8'h12) begin errs++;
      $display("FAIL rd_ptchH got %h want 12", r[7:0]); end
    rd(16'hA400, r);
    checks++; if (r[7:0] !== 8'hEF) begin errs++;
      $display("FAIL rd_rollL got %h want ef", r[7:0]); end
    rd(16'hAB00, r);
    checks++; if (r[7:0] !== 8'hC0) begin errs++;
      $display("FAIL rd_ayH got %h want c0", r[7:0]); end
  endtask

  task automatic test_shadow;
    logic [15:0] r;
    spi_xfer(16'hA200, 16, 4, -1, 16'h5555, r);
    checks++; if (r[7:0] !== 8'h34) begin errs++;
      $display("FAIL shadow_old got %h want 34", r[7:0]); end
    checks++; if (INT !== 1'b1) begin errs++;
      $display("FAIL shadow_int got %b want 1", INT); end
    rd(16'hA200, r);
    checks++; if (r[7:0] !== 8'h55) begin errs++;
      $display("FAIL shadow_new got %h want 55", r[7:0]); end
  endtask

  task automatic test_abort;
    logic [15:0] r;
    spi_xfer(16'h1162, 10, -1, -1, 16'h0, r);
    checks++; if (cfg_11 !== 8'h00) begin errs++;
      $display("FAIL abort_cfg11 got %h want 00", cfg_11); end
    checks++; if (MISO !== 1'b0) begin errs++;
      $display("FAIL abort_miso got %b want 0", MISO); end
    rd(16'h8F00, r);
    checks++; if (r[7:0] !== 8'h6A) begin errs++;
      $display("FAIL abort_next got %h want 6a", r[7:0]); end
  endtask

  task automatic test_status;
    logic [15:0] r;
    rd(16'hA200, r);
    pulse_smpl(16'h0001);
    repeat (5) @(negedge clk);
    pulse_smpl(16'h0002);
    repeat (5) @(negedge clk);
    rd(16'h9E00, r);
`ifdef SNSR_STATUS_EN
    checks++; if (r[7:0] !== 8'h03) begin errs++;
      $display("FAIL status1 got %h want 03", r[7:0]); end
    rd(16'h9E00, r);
    checks++; if (r[7:0] !== 8'h01) begin errs++;
      $display("FAIL status2 got %h want 01", r[7:0]); end
`else
    checks++; if (r[7:0] !== 8'h00) begin errs++;
      $display("FAIL status_off got %h want 00", r[7:0]); end
`endif
  endtask

  task automatic test_reset_mid;
    logic [15:0] r;
    spi_xfer(16'h1433, 16, -1, 3, 16'h0, r);
    checks++; if (cfg_14 !== 8'h00) begin errs++;
      $display("FAIL rstmid_cfg14 got %h want 00", cfg_14); end
    checks++; if (INT !== 1'b0) begin errs++;
      $display("FAIL rstmid_int got %b want 0", INT); end
    rd(16'h8F00, r);
    checks++; if (r[7:0] !== 8'h6A) begin errs++;
      $display("FAIL rstmid_next got %h want 6a", r[7:0]); end
    rd(16'hA300, r);
    checks++; if (r[7:0] !== 8'h00) begin errs++;
      $display("FAIL rstmid_hold got %h want 00", r[7:0]); end
  endtask

  initial begin
    test_reset;
    test_whoami;
    test_write_read;
    test_int;
    test_shadow;
    test_abort;
    test_status;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
